dart_host_seq: RTL and testbench
================================

// Module: dart_host_seq
// PURPOSE
//  Host-side (initiator) end of the DART 16-bit word link: it plays the role the PC plays toward the board.
//  Takes command packets from a local source and drives them out on a dartport-style tx word handshake.
//  Collects the expected number of response words from the rx word stream and forwards them.
//  Used for board-to-board control and for on-chip loopback self-test of the control path.
//  Packet = header + P payload words. Header[15:12] opcode (opaque), [11:8] P (0-15), [7:0] R response words (0-255).
// PARAMETERS
//  TIMEOUT_CYCLES  5000000  max idle cycles allowed between response words (100 ms at 50 MHz); counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clock          in   1   single clock (clock_50 domain)
//  reset          in   1   synchronous, active-high
//  enable         in   1   low = freeze: state, counts, timer hold; no new cmd accepted
//  cmd_data       in   16  command header / payload word
//  cmd_valid      in   1   cmd_data valid
//  cmd_ready      out  1   word accepted when cmd_valid & cmd_ready
//  tx_data        out  16  word to link transmitter
//  tx_valid       out  1   tx_data valid; held stable until tx_ack
//  tx_ack         in   1   1-cycle pulse: transmitter took current tx word
//  rx_data        in   16  word from link receiver
//  rx_valid       in   1   1-cycle pulse, rx_data valid (no backpressure possible)
//  resp_data      out  16  forwarded response word
//  resp_valid     out  1   1-cycle pulse, one cycle after the matching rx_valid
//  resp_last      out  1   with resp_valid on the R-th response word
//  busy           out  1   state != IDLE
//  done           out  1   1-cycle pulse at packet completion (normal or timeout)
//  timeout_err    out  1   sticky; cleared only by reset
//  stray_err      out  1   sticky: rx word arrived with no response outstanding
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready (=enable from the following cycle); counters 0.
//  Single tx holding register: load sets tx_valid; tx_ack clears it. Ack with tx_valid=0 is ignored.
//  cmd_ready = enable & ~tx_valid & (state==IDLE | state==SEND).
//  States:
//   IDLE:  on header accept, load tx reg, latch P and R.
//          P>0 -> SEND. P==0 -> DRAIN.
//   SEND:  each payload accept loads the tx reg and decrements P.
//          Accepting the last payload -> DRAIN.
//   DRAIN: wait for tx_ack of the final word.
//          Then: R remaining>0 -> RESP (timer cleared); R remaining==0 -> IDLE with done.
//   RESP:  each rx_valid decrements R and clears the timer; the final word -> IDLE with done.
//          Otherwise the timer increments each enabled cycle.
//          Timer reaching TIMEOUT_CYCLES -> timeout_err=1, done, IDLE; remaining words are dropped.
//  Response words are counted in SEND, DRAIN and RESP: a fast responder must not be flagged stray.
//  rx_valid in IDLE -> stray_err=1; no resp_valid is produced.
//  resp_valid/resp_data registered: rx word at cycle n appears at n+1.
//  done coincides with resp_last on normal completion with R>0.
//  R==0 and P==0: header sent, done on its ack.
//  enable=0: no state change, timer holds, tx_valid/tx_data hold.
//    tx_ack and rx_valid are still honoured so words in flight are not lost.
//  Reset mid-packet: everything returns to reset values in the next cycle; the partial packet is abandoned.
// TESTING
//  Hdr 16'h3200, payloads AAAA, 5555.
//   -> tx sequence 3200, AAAA, 5555, each held until ack.
//   -> done 1 cycle after the 3rd ack; no resp_valid.
//  Hdr 16'h1003; rx 0001, 0002, 0003.
//   -> 3 resp_valid pulses, each 1 cycle after rx.
//   -> resp_last and done with 0003; busy=0 afterwards.
//  TIMEOUT_CYCLES=100, hdr 16'h1002, one rx word then silence.
//   -> timeout_err=1 and done 100 cycles after that word; cmd_ready=1 next.
//  rx_valid while IDLE -> stray_err=1, resp_valid stays 0.
//  Response word arriving in DRAIN (before tx_ack) -> forwarded and counted; no stray_err.
//  enable=0 for 200 cycles in RESP (TIMEOUT_CYCLES=100) -> no timeout.
//  Reset pulse while tx_valid=1 in SEND -> tx_valid=0, busy=0, errors 0.

Source files
------------

// File: rtl/dart_host_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dart_host_seq
//  Description : Host-side initiator for the DART 16-bit word link. Sends a
//                command packet (header + P payload words) through a single
//                tx holding register, then collects R response words from the
//                rx stream and forwards them. An idle timer bounds the wait
//                between response words.
//  Revision    : 1.0 - initial release
// ============================================================================
module dart_host_seq #(
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic [15:0] cmd_data_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   output logic [15:0] tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ack_i,
   input  logic [15:0] rx_data_i,
   input  logic        rx_valid_i,
   output logic [15:0] resp_data_o,
   output logic        resp_valid_o,
   output logic        resp_last_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        timeout_err_o,
   output logic        stray_err_o
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   // Timer value one cycle before the limit; the increment that would reach
   // TIMEOUT_CYCLES is the one that fires the timeout.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t             state_q;
   logic [15:0]        tx_data_q;
   logic               tx_valid_q;
   logic [3:0]         pay_cnt_q;
   logic [7:0]         rsp_cnt_q;
   logic [TMR_W-1:0]   tmr_q;
   logic [15:0]        resp_data_q;
   logic               resp_valid_q;
   logic               resp_last_q;
   logic               done_q;
   logic               timeout_err_q;
   logic               stray_err_q;

   logic               cmd_fire;
   logic               rx_take;
   logic [7:0]         rsp_cnt_d;

   // Handshake and response-count helpers shared by the sequencer
   always_comb begin
      cmd_ready_o = enable_i & ~tx_valid_q & ((state_q == ST_IDLE) | (state_q == ST_SEND));
      cmd_fire    = cmd_valid_i & cmd_ready_o;
      // Responses are accepted in any non-idle state so a fast responder that
      // answers before the final tx ack is neither lost nor flagged stray.
      rx_take     = rx_valid_i & (state_q != ST_IDLE) & (rsp_cnt_q != 8'd0);
      rsp_cnt_d   = rsp_cnt_q - {7'd0, rx_take};
   end

   // Packet sequencer: tx holding register, response forwarding, timer, flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         tx_data_q     <= 16'd0;
         tx_valid_q    <= 1'b0;
         pay_cnt_q     <= 4'd0;
         rsp_cnt_q     <= 8'd0;
         tmr_q         <= '0;
         resp_data_q   <= 16'd0;
         resp_valid_q  <= 1'b0;
         resp_last_q   <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         stray_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
         done_q       <= 1'b0;

         // Acks and rx words are honoured even while frozen
         if (tx_ack_i) begin
            tx_valid_q <= 1'b0;
         end

         if (rx_take) begin
            resp_data_q  <= rx_data_i;
            resp_valid_q <= 1'b1;
            resp_last_q  <= (rsp_cnt_q == 8'd1);
            rsp_cnt_q    <= rsp_cnt_d;
         end else if (rx_valid_i) begin
            stray_err_q  <= 1'b1;
         end

         if (state_q == ST_RESP && rx_take) begin
            tmr_q <= '0;
         end

         if (enable_i) begin
            case (state_q)
               ST_IDLE: begin
                  if (cmd_fire) begin
                     tx_data_q  <= cmd_data_i;
                     tx_valid_q <= 1'b1;
                     pay_cnt_q  <= cmd_data_i[11:8];
                     rsp_cnt_q  <= cmd_data_i[7:0];
                     state_q    <= (cmd_data_i[11:8] != 4'd0) ? ST_SEND : ST_DRAIN;
                  end
               end
               ST_SEND: begin
                  if (cmd_fire) begin
                     tx_data_q  <= cmd_data_i;
                     tx_valid_q <= 1'b1;
                     pay_cnt_q  <= pay_cnt_q - 4'd1;
                     if (pay_cnt_q == 4'd1) begin
                        state_q <= ST_DRAIN;
                     end
                  end
               end
               ST_DRAIN: begin
                  // Checking tx_valid as well catches an ack that landed while frozen
                  if (~tx_valid_q | tx_ack_i) begin
                     if (rsp_cnt_d == 8'd0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                     end else begin
                        tmr_q   <= '0;
                        state_q <= ST_RESP;
                     end
                  end
               end
               ST_RESP: begin
                  if (rsp_cnt_d == 8'd0) begin
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else if (!rx_take) begin
                     if (tmr_q == TMR_LAST) begin
                        timeout_err_q <= 1'b1;
                        done_q        <= 1'b1;
                        rsp_cnt_q     <= 8'd0;
                        tmr_q         <= '0;
                        state_q       <= ST_IDLE;
                     end else begin
                        tmr_q <= tmr_q + 1'b1;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // Registered outputs
   always_comb begin
      tx_data_o     = tx_data_q;
      tx_valid_o    = tx_valid_q;
      resp_data_o   = resp_data_q;
      resp_valid_o  = resp_valid_q;
      resp_last_o   = resp_last_q;
      busy_o        = (state_q != ST_IDLE);
      done_o        = done_q;
      timeout_err_o = timeout_err_q;
      stray_err_o   = stray_err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_dart_host_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dart_host_seq
//  Description : Directed self-checking bench for dart_host_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dart_host_seq;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        enable_i;
   logic [15:0] cmd_data_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [15:0] tx_data_o;
   logic        tx_valid_o;
   logic        tx_ack_i;
   logic [15:0] rx_data_i;
   logic        rx_valid_i;
   logic [15:0] resp_data_o;
   logic        resp_valid_o;
   logic        resp_last_o;
   logic        busy_o;
   logic        done_o;
   logic        timeout_err_o;
   logic        stray_err_o;

   int n_pass  = 0;
   int n_total = 0;
   int resp_cnt = 0;
   int snap;
   int cyc;

   dart_host_seq #(.TIMEOUT_CYCLES(100)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .enable_i      (enable_i),
      .cmd_data_i    (cmd_data_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .tx_data_o     (tx_data_o),
      .tx_valid_o    (tx_valid_o),
      .tx_ack_i      (tx_ack_i),
      .rx_data_i     (rx_data_i),
      .rx_valid_i    (rx_valid_i),
      .resp_data_o   (resp_data_o),
      .resp_valid_o  (resp_valid_o),
      .resp_last_o   (resp_last_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .timeout_err_o (timeout_err_o),
      .stray_err_o   (stray_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Count forwarded response pulses
   always @(negedge clk_i) begin
      if (resp_valid_o === 1'b1) resp_cnt++;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Present one command word; it is taken on the next edge
   task automatic send_cmd(input string tag, input logic [15:0] w);
      chk({tag, "_ready"}, {31'd0, cmd_ready_o}, 32'd1);
      cmd_data_i  = w;
      cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      chk({tag, "_txv"}, {31'd0, tx_valid_o}, 32'd1);
      chk({tag, "_txd"}, {16'd0, tx_data_o}, {16'd0, w});
   endtask

   task automatic ack();
      tx_ack_i = 1'b1;
      tick();
      tx_ack_i = 1'b0;
   endtask

   task automatic rx(input logic [15:0] w);
      rx_data_i  = w;
      rx_valid_i = 1'b1;
      tick();
      rx_valid_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; enable_i = 1'b1; cmd_data_i = 16'd0; cmd_valid_i = 1'b0;
      tx_ack_i = 1'b0; rx_data_i = 16'd0; rx_valid_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;
      tick();

      // Reset state
      chk("rst_busy",  {31'd0, busy_o},        32'd0);
      chk("rst_txv",   {31'd0, tx_valid_o},    32'd0);
      chk("rst_done",  {31'd0, done_o},        32'd0);
      chk("rst_resp",  {31'd0, resp_valid_o},  32'd0);
      chk("rst_terr",  {31'd0, timeout_err_o}, 32'd0);
      chk("rst_serr",  {31'd0, stray_err_o},   32'd0);
      chk("rst_ready", {31'd0, cmd_ready_o},   32'd1);

      // Header 3200 with two payloads, no responses
      snap = resp_cnt;
      send_cmd("t1_hdr", 16'h3200);
      chk("t1_ready_blocked", {31'd0, cmd_ready_o}, 32'd0);
      tick(); tick();
      chk("t1_hold_txd", {16'd0, tx_data_o}, 32'h3200);
      ack();
      chk("t1_ack_clr", {31'd0, tx_valid_o}, 32'd0);
      send_cmd("t1_p0", 16'hAAAA);
      tick();
      ack();
      chk("t1_nodone_mid", {31'd0, done_o}, 32'd0);
      send_cmd("t1_p1", 16'h5555);
      ack();
      chk("t1_done", {31'd0, done_o}, 32'd1);
      chk("t1_busy", {31'd0, busy_o}, 32'd0);
      tick();
      chk("t1_done_pulse", {31'd0, done_o}, 32'd0);
      chk("t1_no_resp", resp_cnt, snap);

      // Header 1003, three responses
      send_cmd("t2_hdr", 16'h1003);
      ack();
      chk("t2_busy_resp", {31'd0, busy_o}, 32'd1);
      chk("t2_nodone", {31'd0, done_o}, 32'd0);
      rx(16'h0001);
      chk("t2_r1_v",    {31'd0, resp_valid_o}, 32'd1);
      chk("t2_r1_d",    {16'd0, resp_data_o},  32'h0001);
      chk("t2_r1_last", {31'd0, resp_last_o},  32'd0);
      tick();
      chk("t2_r1_pulse", {31'd0, resp_valid_o}, 32'd0);
      rx(16'h0002);
      chk("t2_r2_d",    {16'd0, resp_data_o},  32'h0002);
      chk("t2_r2_done", {31'd0, done_o},       32'd0);
      tick(); tick();
      rx(16'h0003);
      chk("t2_r3_v",    {31'd0, resp_valid_o}, 32'd1);
      chk("t2_r3_d",    {16'd0, resp_data_o},  32'h0003);
      chk("t2_r3_last", {31'd0, resp_last_o},  32'd1);
      chk("t2_r3_done", {31'd0, done_o},       32'd1);
      tick();
      chk("t2_idle", {31'd0, busy_o}, 32'd0);

      // Response arrives in DRAIN before the header ack
      send_cmd("t3_hdr", 16'h1001);
      rx(16'h00BE);
      chk("t3_fwd_v",    {31'd0, resp_valid_o}, 32'd1);
      chk("t3_fwd_d",    {16'd0, resp_data_o},  32'h00BE);
      chk("t3_fwd_last", {31'd0, resp_last_o},  32'd1);
      chk("t3_no_stray", {31'd0, stray_err_o},  32'd0);
      chk("t3_still_busy", {31'd0, busy_o},     32'd1);
      ack();
      chk("t3_done", {31'd0, done_o}, 32'd1);
      chk("t3_idle", {31'd0, busy_o}, 32'd0);

      // Freeze for 200 cycles in RESP: no timeout
      send_cmd("t4_hdr", 16'h1001);
      ack();
      enable_i = 1'b0;
      for (int i = 0; i < 200; i++) tick();
      chk("t4_no_terr", {31'd0, timeout_err_o}, 32'd0);
      chk("t4_busy",    {31'd0, busy_o},        32'd1);
      chk("t4_ready0",  {31'd0, cmd_ready_o},   32'd0);
      enable_i = 1'b1;
      rx(16'h0042);
      chk("t4_done", {31'd0, done_o},      32'd1);
      chk("t4_last", {31'd0, resp_last_o}, 32'd1);
      tick();

      // Timeout: one response then silence
      send_cmd("t5_hdr", 16'h1002);
      ack();
      rx(16'h0001);
      chk("t5_r1_v", {31'd0, resp_valid_o}, 32'd1);
      cyc = 0;
      while (done_o !== 1'b1 && cyc < 300) begin
         tick();
         cyc++;
      end
      chk("t5_latency", cyc, 100);
      chk("t5_terr",  {31'd0, timeout_err_o}, 32'd1);
      chk("t5_ready", {31'd0, cmd_ready_o},   32'd1);
      chk("t5_idle",  {31'd0, busy_o},        32'd0);
      tick();

      // Stray word while idle
      snap = resp_cnt;
      chk("t6_serr_before", {31'd0, stray_err_o}, 32'd0);
      rx(16'h7777);
      tick();
      chk("t6_serr",    {31'd0, stray_err_o}, 32'd1);
      chk("t6_no_resp", resp_cnt, snap);

      // Reset mid-packet in SEND
      send_cmd("t7_hdr", 16'h3200);
      chk("t7_busy", {31'd0, busy_o}, 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("t7_txv",  {31'd0, tx_valid_o},    32'd0);
      chk("t7_busy0",{31'd0, busy_o},        32'd0);
      chk("t7_terr", {31'd0, timeout_err_o}, 32'd0);
      chk("t7_serr", {31'd0, stray_err_o},   32'd0);
      tick();
      chk("t7_ready", {31'd0, cmd_ready_o},  32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
